// File: rtl/ssd_scan_controller_pkg.sv
// Shared constants and types for the seven-segment scan path (scan controller,
// anode/BCD control and ssd_driver all agree on these encodings).
package ssd_scan_controller_pkg;

  localparam int         NUM_DIGITS = 8;
  localparam logic [3:0] BLANK_CODE = 4'hF;
  localparam logic [7:0] ANODE_OFF  = 8'hFF;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_e;

  function automatic logic [7:0] anode_sel(input logic [2:0] idx);
    return ~(8'h01 << idx);
  endfunction

endpackage

// File: rtl/ssd_dwell_timer.sv
// Dwell counter: counts cycles spent in the current scan slot and flags the last one.
module ssd_dwell_timer #(
  parameter int CNT_W = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic [CNT_W-1:0] term_i,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // done marks the final cycle of a dwell of term_i cycles
  assign done_o = (cnt_q == term_i - CNT_W'(1));

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clear_i) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ssd_scan_controller.sv
// Time-multiplexed scan scheduler for an 8-digit display: blanking, leading-zero
// suppression, per-digit enables and frame-synchronous double-buffered digit data.
module ssd_scan_controller
  import ssd_scan_controller_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int CNT_W        = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] digits_in,
  input  logic [7:0]  digit_en,
  input  logic        lz_blank,
  output logic [7:0]  anode,
  output logic [3:0]  one_digit,
  output logic        frame_done
);

  localparam logic [CNT_W-1:0] SHOW_TERM  = CNT_W'(REFRESH_DIV);
  // a zero-length blank still costs the single post-reset BLANK cycle
  localparam logic [CNT_W-1:0] BLANK_TERM = CNT_W'((BLANK_CYCLES == 0) ? 1 : BLANK_CYCLES);

  scan_state_e state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [31:0] stg_dig_q, stg_dig_d, sh_dig_q, sh_dig_d;
  logic [7:0]  stg_en_q, stg_en_d, sh_en_q, sh_en_d;
  logic        stg_lz_q, stg_lz_d, sh_lz_q, sh_lz_d;
  logic        pending_q, pending_d;
  logic [7:0]  anode_q, anode_d;
  logic [3:0]  digit_q, digit_d;

  logic [CNT_W-1:0] term;
  logic             dwell_done;
  logic             commit;
  logic [7:0]       zero_above;
  logic [7:0]       vis_mask;

  assign term = (state_q == ST_SHOW) ? SHOW_TERM : BLANK_TERM;

  ssd_dwell_timer #(.CNT_W(CNT_W)) u_dwell (
    .clk     (clk),
    .rst     (rst),
    .clear_i (dwell_done),
    .term_i  (term),
    .done_o  (dwell_done)
  );

  assign commit     = dwell_done && (state_q == ST_SHOW) && (idx_q == 3'd7);
  assign frame_done = commit;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    stg_dig_d = stg_dig_q;
    stg_en_d  = stg_en_q;
    stg_lz_d  = stg_lz_q;
    sh_dig_d  = sh_dig_q;
    sh_en_d   = sh_en_q;
    sh_lz_d   = sh_lz_q;
    pending_d = pending_q;
    anode_d   = ANODE_OFF;
    digit_d   = BLANK_CODE;

    if (dwell_done) begin
      if (state_q == ST_BLANK) begin
        state_d = ST_SHOW;
      end else begin
        idx_d   = idx_q + 3'd1;
        state_d = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;
      end
    end

    if (load) begin
      stg_dig_d = digits_in;
      stg_en_d  = digit_en;
      stg_lz_d  = lz_blank;
      pending_d = 1'b1;
    end

    // a load coinciding with the frame wrap bypasses staging
    if (commit) begin
      if (load) begin
        sh_dig_d = digits_in;
        sh_en_d  = digit_en;
        sh_lz_d  = lz_blank;
      end else if (pending_q) begin
        sh_dig_d = stg_dig_q;
        sh_en_d  = stg_en_q;
        sh_lz_d  = stg_lz_q;
      end
      pending_d = 1'b0;
    end

    zero_above[NUM_DIGITS-1] = (sh_dig_d[31:28] == 4'h0);
    for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
      zero_above[i] = zero_above[i+1] && (sh_dig_d[i*4 +: 4] == 4'h0);
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      vis_mask[i] = sh_en_d[i] && !(sh_lz_d && (i != 0) && zero_above[i]);
    end

    // outputs follow the next state so they line up with it when registered
    if ((state_d == ST_SHOW) && vis_mask[idx_d]) begin
      anode_d = anode_sel(idx_d);
      digit_d = sh_dig_d[{idx_d, 2'b00} +: 4];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_BLANK;
      idx_q     <= 3'd0;
      stg_dig_q <= '0;
      stg_en_q  <= '0;
      stg_lz_q  <= 1'b0;
      sh_dig_q  <= '0;
      sh_en_q   <= 8'h00;
      sh_lz_q   <= 1'b0;
      pending_q <= 1'b0;
      anode_q   <= ANODE_OFF;
      digit_q   <= BLANK_CODE;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      stg_dig_q <= stg_dig_d;
      stg_en_q  <= stg_en_d;
      stg_lz_q  <= stg_lz_d;
      sh_dig_q  <= sh_dig_d;
      sh_en_q   <= sh_en_d;
      sh_lz_q   <= sh_lz_d;
      pending_q <= pending_d;
      anode_q   <= anode_d;
      digit_q   <= digit_d;
    end
  end

  assign anode     = anode_q;
  assign one_digit = digit_q;

endmodule

// File: tb/tb_ssd_scan_controller.sv
// Directed bench for ssd_scan_controller: one DUT with blanking, one without.
module tb_ssd_scan_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load = 1'b0;
  logic [31:0] digits_in = '0;
  logic [7:0]  digit_en = '0;
  logic        lz_blank = 1'b0;
  logic [7:0]  anode, anode_nb;
  logic [3:0]  one_digit, one_digit_nb;
  logic        frame_done, frame_done_nb;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  ssd_scan_controller #(.REFRESH_DIV(4), .BLANK_CYCLES(2), .CNT_W(17)) dut (
    .clk(clk), .rst(rst), .load(load), .digits_in(digits_in), .digit_en(digit_en),
    .lz_blank(lz_blank), .anode(anode), .one_digit(one_digit), .frame_done(frame_done)
  );

  ssd_scan_controller #(.REFRESH_DIV(4), .BLANK_CYCLES(0), .CNT_W(17)) dut_nb (
    .clk(clk), .rst(rst), .load(load), .digits_in(digits_in), .digit_en(digit_en),
    .lz_blank(lz_blank), .anode(anode_nb), .one_digit(one_digit_nb), .frame_done(frame_done_nb)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic pulse_load(input logic [31:0] d, input logic [7:0] en, input logic lz);
    load = 1'b1; digits_in = d; digit_en = en; lz_blank = lz;
    step();
    load = 1'b0;
  endtask

  // expected {anode, nibble} for a SHOW slot s
  function automatic logic [11:0] model(input logic [31:0] d, input logic [7:0] en,
                                        input logic lz, input int s);
    logic [31:0] hi;
    logic        vis;
    logic [7:0]  an;
    hi  = d >> (4 * s);
    vis = en[s] && !(lz && (s != 0) && (hi == 32'h0));
    an  = ~(8'h01 << s);
    return vis ? {an, d[4*s +: 4]} : 12'hFFF;
  endfunction

  task automatic wait_fd(input string tag, input bit nb, input int bound);
    int n;
    bit found;
    n = 0;
    found = 1'b0;
    while (!found && n < bound) begin
      step();
      n++;
      if ((nb ? frame_done_nb : frame_done) === 1'b1) found = 1'b1;
    end
    chk(tag, 32'(found), 32'd1);
  endtask

  // caller is at sample j0 of a frame; ends on that frame's frame_done sample
  task automatic run_frame(input string tag, input bit nb, input logic [31:0] d,
                           input logic [7:0] en, input logic lz, input int j0);
    int slot_len, blank, per;
    logic [11:0] exp, obs;
    slot_len = nb ? 4 : 6;
    blank    = nb ? 0 : 2;
    per      = 8 * slot_len;
    for (int j = j0; j < per; j++) begin
      exp = ((j % slot_len) < blank) ? 12'hFFF : model(d, en, lz, j / slot_len);
      obs = nb ? {anode_nb, one_digit_nb} : {anode, one_digit};
      chk($sformatf("%s_out_j%0d", tag, j), 32'(obs), 32'(exp));
      chk($sformatf("%s_fd_j%0d", tag, j), 32'(nb ? frame_done_nb : frame_done),
          32'(j == per - 1));
      if (j < per - 1) step();
    end
  endtask

  // dark display after reset release: count lit samples and frame_done positions
  task automatic dark_run(input string tag);
    int lit, fd_cnt, fd1, fd2, nb_cnt, nb1;
    lit = 0; fd_cnt = 0; fd1 = -1; fd2 = -1; nb_cnt = 0; nb1 = -1;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (anode !== 8'hFF || one_digit !== 4'hF || anode_nb !== 8'hFF) lit++;
      if (frame_done === 1'b1) begin
        fd_cnt++;
        if (fd1 < 0) fd1 = i; else if (fd2 < 0) fd2 = i;
      end
      if (frame_done_nb === 1'b1) begin
        nb_cnt++;
        if (nb1 < 0) nb1 = i;
      end
    end
    chk({tag, "_lit"}, 32'(lit), 32'd0);
    chk({tag, "_fd_count"}, 32'(fd_cnt), 32'd2);
    chk({tag, "_fd_first"}, 32'(fd1), 32'd47);
    chk({tag, "_fd_second"}, 32'(fd2), 32'd95);
    chk({tag, "_nb_fd_count"}, 32'(nb_cnt), 32'd3);
    chk({tag, "_nb_fd_first"}, 32'(nb1), 32'd32);
  endtask

  initial begin
    // reset state
    #2 rst = 1'b1;
    #1;
    chk("rst_anode", 32'(anode), 32'hFF);
    chk("rst_digit", 32'(one_digit), 32'hF);
    chk("rst_fd", 32'(frame_done), 32'h0);
    chk("rst_nb_anode", 32'(anode_nb), 32'hFF);
    @(negedge clk);
    rst = 1'b0;
    dark_run("boot");

    // leading-zero suppression on
    pulse_load(32'h0000_0042, 8'hFF, 1'b1);
    wait_fd("wait_lz1", 1'b0, 60);
    step();
    run_frame("lz1", 1'b0, 32'h0000_0042, 8'hFF, 1'b1, 0);

    // suppression off: every digit lit
    step();
    pulse_load(32'h0000_0042, 8'hFF, 1'b0);
    wait_fd("wait_lz0", 1'b0, 60);
    step();
    run_frame("lz0", 1'b0, 32'h0000_0042, 8'hFF, 1'b0, 0);

    // upper four digits disabled
    step();
    pulse_load(32'h0000_0042, 8'h0F, 1'b0);
    wait_fd("wait_en", 1'b0, 60);
    step();
    run_frame("en0F", 1'b0, 32'h0000_0042, 8'h0F, 1'b0, 0);

    // two loads mid-frame: old data holds, then last load wins
    step();
    pulse_load(32'h1111_1111, 8'hFF, 1'b0);
    step();
    pulse_load(32'h2222_2222, 8'hFF, 1'b0);
    run_frame("hold_old", 1'b0, 32'h0000_0042, 8'h0F, 1'b0, 3);
    step();
    run_frame("last_wins", 1'b0, 32'h2222_2222, 8'hFF, 1'b0, 0);

    // load coinciding with frame wrap goes straight to the display
    pulse_load(32'h0000_4095, 8'hFF, 1'b1);
    run_frame("load_at_fd", 1'b0, 32'h0000_4095, 8'hFF, 1'b1, 0);

    // reset in the middle of the idx 3 SHOW slot
    step();
    for (int k = 0; k < 21; k++) step();
    chk("pre_rst_anode", 32'(anode), 32'hF7);
    chk("pre_rst_digit", 32'(one_digit), 32'h4);
    rst = 1'b1;
    #1;
    chk("mid_rst_anode", 32'(anode), 32'hFF);
    chk("mid_rst_digit", 32'(one_digit), 32'hF);
    chk("mid_rst_fd", 32'(frame_done), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    dark_run("post_rst");

    // no-blanking build: back-to-back digits, 32-cycle frame
    pulse_load(32'h8765_4321, 8'hFF, 1'b0);
    wait_fd("wait_nb", 1'b1, 40);
    step();
    run_frame("nb", 1'b1, 32'h8765_4321, 8'hFF, 1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
